mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Memory-side responder for the core's icache/dcache request interface. It accepts one request at a time from a cache port: a valid flag plus address, write-enable and write data. After a fixed, parameterised latency it returns a one-cycle data-valid pulse carrying the read data. It is backed by an internal word-addressed RAM. Two instances sit beside the core, one serving instruction fetch and one serving data, for simulation and FPGA bring-up.

Parameters:
DATA_W, 64, data width in bits; must be 64.
ADDR_W, 64, address width.
DEPTH_LOG2, 12, log2 of the number of 64-bit words in the RAM.
LATENCY, 2, cycles from acceptance edge to response; must be >= 1.
BASE_ADDR, 64'h0000_0000_8000_0000, byte address that maps to word 0.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid_i  in  1  request present. The requester holds it, together with addr/wen/data, until it sees data_valid_o.
addr_i  in  ADDR_W  request byte address.
data_wen_i  in  1  1 = write, 0 = read.
data_i  in  DATA_W  write data.
data_valid_o  out  1  one-cycle response pulse.
data_o  out  DATA_W  response data; valid only while data_valid_o = 1.
err_o  out  1  error flag qualified by data_valid_o.
busy_o  out  1  high in BUSY and RESP states.

Behaviour:
- Reset (async, active-high) forces:
  - state IDLE, latency counter 0, captured request registers 0;
  - data_valid_o = 0, data_o = 0, err_o = 0, busy_o = 0.
  - RAM contents are not reset. A write pending at reset is dropped and never committed.
- State machine IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - if req_valid_i = 1 at an edge, capture addr_i, data_wen_i and data_i;
  - load counter with LATENCY-1 and go to BUSY.
- BUSY:
  - inputs are ignored;
  - counter decrements each edge;
  - at the edge where counter = 0, perform the access and go to RESP.
  - The access registers data_o and err_o and sets data_valid_o = 1.
- RESP:
  - data_valid_o = 1 for exactly this one cycle;
  - req_valid_i is ignored in this cycle, because the requester may still be holding the old request;
  - the next edge returns to IDLE and clears data_valid_o, data_o and err_o.
- Timing: if accepted at edge N, data_valid_o is high in the cycle after edge N+LATENCY. Peak throughput is one request per LATENCY+2 cycles.
- Address map:
  - off = addr - BASE_ADDR (ADDR_W-bit unsigned);
  - index = off[DEPTH_LOG2+2:3].
  - In-range means addr >= BASE_ADDR and off >> 3 < 2^DEPTH_LOG2.
- Read, in range:
  - addr[2] = 0: data_o = mem[index];
  - addr[2] = 1: data_o = {32'b0, mem[index][63:32]}, so a 4-byte-aligned fetch delivers the instruction on data_o[31:0];
  - addr[1:0] is ignored.
- Write, in range with addr[2:0] = 0:
  - mem[index] <= data at the access edge;
  - data_o = written data; err_o = 0.
- Errors:
  - Write with addr[2:0] != 0: no RAM update, err_o = 1, data_o = 0.
  - Any out-of-range access: no RAM update, err_o = 1, data_o = 0.
- Read-after-write: a read accepted after a write's response observes the new value.
- busy_o = 1 whenever state != IDLE. It is combinational from state, with no other input dependence.

Test Plan:
1. Reset then idle, with rst asserted mid-cycle (asynchronously) -> all outputs 0 immediately; with req_valid_i = 0 for 10 cycles, data_valid_o stays 0.
2. LATENCY=2: write 0xDEAD_BEEF_0123_4567 to 0x8000_0010 and hold req until the response -> data_valid_o is high exactly 3 cycles after the acceptance edge cycle, for 1 cycle, with err_o = 0. Then read 0x8000_0010 -> data_o = 0xDEAD_BEEF_0123_4567.
3. Upper-half fetch: read 0x8000_0014 after test 2 -> data_o = 0x0000_0000_DEAD_BEEF.
4. Held request: keep req_valid_i high continuously across the RESP cycle -> exactly one response per LATENCY+2 cycles; no duplicate response in the cycle after RESP.
5. Errors:
   - read 0x7FFF_FFF8 -> data_valid_o = 1, err_o = 1, data_o = 0;
   - write to 0x8000_0000 + 8·2^DEPTH_LOG2 -> err_o = 1;
   - write to 0x8000_0004 -> err_o = 1, and a later read of 0x8000_0000 is unchanged.
6. Reset mid-operation: accept a write of 0x1111 to 0x8000_0020, assert rst in BUSY -> no response; a subsequent read of 0x8000_0020 returns the prior contents, not 0x1111.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// mem_responder: fixed-latency, one-request-at-a-time memory responder backed by a word RAM.
// Revision: 1.0
module mem_responder #(
   parameter int                DATA_W     = 64,
   parameter int                ADDR_W     = 64,
   parameter int                DEPTH_LOG2 = 12,
   parameter int                LATENCY    = 2,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 64'h0000_0000_8000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              data_wen_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              data_valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              err_o,
   output logic              busy_o
);

   localparam int                CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [ADDR_W-1:0] WORDS  = ADDR_W'(1) << DEPTH_LOG2;
   localparam logic [1:0]        S_IDLE = 2'd0;
   localparam logic [1:0]        S_BUSY = 2'd1;
   localparam logic [1:0]        S_RESP = 2'd2;

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [CNT_W-1:0]      cnt;
   logic [ADDR_W-1:0]     req_addr;
   logic                  req_wen;
   logic [DATA_W-1:0]     req_data;
   logic [DATA_W-1:0]     mem [0:(1<<DEPTH_LOG2)-1];

   logic [ADDR_W-1:0]     word_off;
   logic [DEPTH_LOG2-1:0] index;
   logic [DATA_W-1:0]     rd_word;
   logic                  in_range;
   logic                  bad;
   logic                  access;

   // Decode works on the captured request so inputs may change freely while BUSY.
   assign word_off = (req_addr - BASE_ADDR) >> 3;
   assign in_range = (req_addr >= BASE_ADDR) && (word_off < WORDS);
   assign index    = word_off[DEPTH_LOG2-1:0];
   assign rd_word  = mem[index];
   assign bad      = !in_range || (req_wen && (req_addr[2:0] != 3'd0));
   assign access   = (state == S_BUSY) && (cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (req_valid_i) state_nxt = S_BUSY;
         S_BUSY:  if (cnt == '0)   state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt          <= '0;
         req_addr     <= '0;
         req_wen      <= 1'b0;
         req_data     <= '0;
         data_valid_o <= 1'b0;
         data_o       <= '0;
         err_o        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid_i) begin
                  req_addr <= addr_i;
                  req_wen  <= data_wen_i;
                  req_data <= data_i;
                  cnt      <= CNT_W'(LATENCY - 1);
               end
            end
            S_BUSY: begin
               if (cnt == '0) begin
                  data_valid_o <= 1'b1;
                  err_o        <= bad;
                  if (bad) begin
                     data_o <= '0;
                  end else if (req_wen) begin
                     data_o <= req_data;
                  end else if (req_addr[2]) begin
                     // Upper-half read puts the second 32-bit instruction on the low lanes.
                     data_o <= {{(DATA_W/2){1'b0}}, rd_word[DATA_W-1:DATA_W/2]};
                  end else begin
                     data_o <= rd_word;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               data_valid_o <= 1'b0;
               data_o       <= '0;
               err_o        <= 1'b0;
            end
         endcase
      end
   end

   // RAM is not reset; an aborted write never reaches the access edge.
   always_ff @(posedge clk) begin
      if (access && !bad && req_wen) begin
         mem[index] <= req_data;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// tb_mem_responder: directed stimulus with a transaction-level reference model.
// Revision: 1.0
module tb_mem_responder;

   localparam int          LAT  = 2;
   localparam int          DL2  = 12;
   localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        data_wen = 1'b0;
   logic [63:0] addr = '0;
   logic [63:0] wdata = '0;
   logic        data_valid_o;
   logic [63:0] data_o;
   logic        err_o;
   logic        busy_o;

   always #5 clk = ~clk;

   mem_responder #(
      .DATA_W(64), .ADDR_W(64), .DEPTH_LOG2(DL2), .LATENCY(LAT), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .rst(rst), .req_valid_i(req_valid), .addr_i(addr),
      .data_wen_i(data_wen), .data_i(wdata), .data_valid_o(data_valid_o),
      .data_o(data_o), .err_o(err_o), .busy_o(busy_o)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: a request accepted at edge a answers after edge a+LAT,
   // and the next request can be taken at edge a+LAT+2.
   logic [63:0] mm [longint unsigned];
   int          cyc = 0;
   logic        m_act = 1'b0;
   int          m_acc = 0;
   logic [63:0] m_addr = '0;
   logic [63:0] m_data = '0;
   logic        m_wen = 1'b0;
   logic        exp_valid = 1'b0;
   logic        exp_err = 1'b0;
   logic        exp_busy = 1'b0;
   logic [63:0] exp_data = '0;
   logic [64:0] r;

   function automatic logic [64:0] predict(input logic [63:0] a, input logic w, input logic [63:0] d);
      logic [63:0] word;
      if (a < BASE || (a - BASE) >= 64'd8 * (64'd1 << DL2)) return {1'b1, 64'd0};
      if (w) return ((a % 8) != 0) ? {1'b1, 64'd0} : {1'b0, d};
      word = mm[(a - BASE) / 8];
      return {1'b0, a[2] ? (word >> 32) : word};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_act     <= 1'b0;
         exp_valid <= 1'b0;
         exp_data  <= '0;
         exp_err   <= 1'b0;
         exp_busy  <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         if (m_act && cyc == m_acc + LAT) begin
            r = predict(m_addr, m_wen, m_data);
            exp_valid <= 1'b1;
            exp_err   <= r[64];
            exp_data  <= r[63:0];
            if (m_wen && !r[64]) mm[(m_addr - BASE) / 8] = m_data;
         end else begin
            exp_valid <= 1'b0;
            exp_err   <= 1'b0;
            exp_data  <= '0;
         end
         if (req_valid && (!m_act || (cyc - m_acc) >= LAT + 2)) begin
            m_act    <= 1'b1;
            m_acc    <= cyc;
            m_addr   <= addr;
            m_wen    <= data_wen;
            m_data   <= wdata;
            exp_busy <= 1'b1;
         end else begin
            exp_busy <= m_act && ((cyc - m_acc) <= LAT);
         end
      end
   end

   logic en = 1'b0;

   always @(negedge clk) begin
      if (en && !rst) begin
         chk("valid", {63'd0, data_valid_o}, {63'd0, exp_valid});
         chk("data",  data_o, exp_data);
         chk("err",   {63'd0, err_o}, {63'd0, exp_err});
         chk("busy",  {63'd0, busy_o}, {63'd0, exp_busy});
      end
   end

   // Caller is at a negedge with the DUT idle; returns response fields and cycles to response.
   task automatic do_req(input logic [63:0] a, input logic w, input logic [63:0] d,
                         output logic [63:0] rdat, output logic rerr, output int n);
      addr = a; data_wen = w; wdata = d; req_valid = 1'b1;
      n = 0; rdat = '0; rerr = 1'b0;
      while (1) begin
         @(negedge clk);
         n++;
         if (data_valid_o) begin
            rdat = data_o;
            rerr = err_o;
            break;
         end
         if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout: no data_valid after %0d cycles, expected after %0d", n, LAT + 1);
            break;
         end
      end
      req_valid = 1'b0;
      @(negedge clk);
   endtask

   logic [63:0] rd;
   logic        re;
   int          lat;
   int          nv;

   initial begin
      // Asynchronous reset in the middle of a cycle.
      #3 rst = 1'b1;
      #1;
      chk("rst_valid", {63'd0, data_valid_o}, 64'd0);
      chk("rst_data",  data_o, 64'd0);
      chk("rst_err",   {63'd0, err_o}, 64'd0);
      chk("rst_busy",  {63'd0, busy_o}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      en  = 1'b1;
      nv  = 0;
      repeat (10) begin @(negedge clk); nv += int'(data_valid_o); end
      chk("idle_no_resp", 64'(nv), 64'd0);

      do_req(64'h8000_0010, 1'b1, 64'hDEAD_BEEF_0123_4567, rd, re, lat);
      chk("wr_latency", 64'(lat), 64'(LAT + 1));
      chk("wr_data", rd, 64'hDEAD_BEEF_0123_4567);
      chk("wr_err", {63'd0, re}, 64'd0);
      do_req(64'h8000_0010, 1'b0, 64'd0, rd, re, lat);
      chk("rd_data", rd, 64'hDEAD_BEEF_0123_4567);
      chk("rd_latency", 64'(lat), 64'(LAT + 1));
      do_req(64'h8000_0014, 1'b0, 64'd0, rd, re, lat);
      chk("rd_upper", rd, 64'h0000_0000_DEAD_BEEF);

      // Held request: one response every LAT+2 cycles.
      addr = 64'h8000_0010; data_wen = 1'b0; req_valid = 1'b1;
      nv = 0;
      repeat (12) begin @(negedge clk); nv += int'(data_valid_o); end
      req_valid = 1'b0;
      chk("held_resp_count", 64'(nv), 64'd3);
      repeat (4) @(negedge clk);

      do_req(64'h7FFF_FFF8, 1'b0, 64'd0, rd, re, lat);
      chk("below_base_err", {63'd0, re}, 64'd1);
      chk("below_base_data", rd, 64'd0);
      do_req(64'h8000_8000, 1'b1, 64'h1234, rd, re, lat);
      chk("above_top_err", {63'd0, re}, 64'd1);
      do_req(64'h8000_0000, 1'b1, 64'h0123_4567_89AB_CDEF, rd, re, lat);
      do_req(64'h8000_0004, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, rd, re, lat);
      chk("misalign_err", {63'd0, re}, 64'd1);
      chk("misalign_data", rd, 64'd0);
      do_req(64'h8000_0000, 1'b0, 64'd0, rd, re, lat);
      chk("misalign_unchanged", rd, 64'h0123_4567_89AB_CDEF);

      // Reset while BUSY drops the pending write.
      do_req(64'h8000_0020, 1'b1, 64'hAAAA_5555_0000_2020, rd, re, lat);
      addr = 64'h8000_0020; data_wen = 1'b1; wdata = 64'h1111; req_valid = 1'b1;
      @(negedge clk);
      #2 rst = 1'b1;
      req_valid = 1'b0;
      #1;
      chk("midrst_busy", {63'd0, busy_o}, 64'd0);
      chk("midrst_valid", {63'd0, data_valid_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      nv = 0;
      repeat (5) begin @(negedge clk); nv += int'(data_valid_o); end
      chk("midrst_no_resp", 64'(nv), 64'd0);
      do_req(64'h8000_0020, 1'b0, 64'd0, rd, re, lat);
      chk("midrst_prior", rd, 64'hAAAA_5555_0000_2020);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
